// File: rtl/if_id_stage.sv
// Instruction fetch stage with the IF/ID pipeline register for the pipelined MIPS core.
// It holds the PC, applies load-use stalls and decode redirects, and counts accepted fetches.
module if_id_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0000
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    input  logic [31:0] inst_i,
    input  logic        stall_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic [31:0] pc_o,
    output logic [31:0] id_inst_o,
    output logic [5:0]  id_op_o,
    output logic [31:0] id_pc_plus4_o,
    output logic        id_valid_o,
    output logic [31:0] fetch_cnt_o
);

    typedef enum logic {IDLE, RUN} state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] inst_q, inst_d;
    logic [31:0] pc4_q, pc4_d;
    logic        valid_q, valid_d;
    logic [31:0] cnt_q, cnt_d;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            pc_q    <= RESET_PC;
            inst_q  <= NOP_INST;
            pc4_q   <= 32'd0;
            valid_q <= 1'b0;
            cnt_q   <= 32'd0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            inst_q  <= inst_d;
            pc4_q   <= pc4_d;
            valid_q <= valid_d;
            cnt_q   <= cnt_d;
        end
    end

    // Stall beats redirect: a redirect seen during a stall is dropped and must be re-issued.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        inst_d  = inst_q;
        pc4_d   = pc4_q;
        valid_d = valid_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                pc_d    = RESET_PC;
                inst_d  = NOP_INST;
                pc4_d   = 32'd0;
                valid_d = 1'b0;
                if (start_i) state_d = RUN;
            end
            RUN: begin
                if (stall_i) begin
                    state_d = RUN;
                end else if (redirect_i) begin
                    pc_d    = redirect_pc_i & ~32'h0000_0003;
                    inst_d  = NOP_INST;
                    pc4_d   = 32'd0;
                    valid_d = 1'b0;
                end else begin
                    inst_d  = inst_i;
                    pc4_d   = pc_q + 32'd4;
                    valid_d = 1'b1;
                    pc_d    = pc_q + 32'd4;
                    cnt_d   = cnt_q + 32'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign pc_o          = pc_q;
    assign id_inst_o     = inst_q;
    assign id_op_o       = inst_q[31:26];
    assign id_pc_plus4_o = pc4_q;
    assign id_valid_o    = valid_q;
    assign fetch_cnt_o   = cnt_q;

endmodule

// File: tb/tb_if_id_stage.sv
// Scoreboard bench for if_id_stage: a reference model queues the expected IF/ID state
// for each edge, and the DUT outputs are popped and compared just after that edge.
module tb_if_id_stage;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        start_i = 1'b0;
    logic [31:0] inst_i;
    logic        stall_i = 1'b0;
    logic        redirect_i = 1'b0;
    logic [31:0] redirect_pc_i = 32'd0;
    logic [31:0] pc_o;
    logic [31:0] id_inst_o;
    logic [5:0]  id_op_o;
    logic [31:0] id_pc_plus4_o;
    logic        id_valid_o;
    logic [31:0] fetch_cnt_o;

    if_id_stage dut (
        .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .inst_i(inst_i),
        .stall_i(stall_i), .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i),
        .pc_o(pc_o), .id_inst_o(id_inst_o), .id_op_o(id_op_o),
        .id_pc_plus4_o(id_pc_plus4_o), .id_valid_o(id_valid_o), .fetch_cnt_o(fetch_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    function automatic logic [31:0] imem(input logic [31:0] a);
        if (a == 32'h0000_0000) return 32'h2008_0005;
        if (a == 32'h0000_0010) return 32'h8C09_0000;
        return 32'h2400_0000 | (a & 32'h0000_FFFF) | 32'h0001_0000;
    endfunction

    assign inst_i = imem(pc_o);

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
        logic [31:0] pc4;
        logic        v;
        logic [31:0] cnt;
    } exp_t;

    exp_t        sb[$];
    int          n_cmp = 0;
    int          n_err = 0;
    logic        m_run = 1'b0;
    logic [31:0] m_pc = 32'd0, m_inst = 32'd0, m_pc4 = 32'd0, m_cnt = 32'd0;
    logic        m_v = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One clock: drive inputs at negedge, advance the model, compare just after posedge.
    task automatic cyc(input logic r, input logic s, input logic st, input logic rd,
                       input logic [31:0] rpc);
        exp_t e;
        @(negedge clk_i);
        rst_i = r; start_i = s; stall_i = st; redirect_i = rd; redirect_pc_i = rpc;
        if (r) begin
            m_run = 0; m_pc = 0; m_inst = 0; m_pc4 = 0; m_v = 0; m_cnt = 0;
        end else if (!m_run) begin
            if (s) m_run = 1;
        end else if (st) begin
            m_run = 1;
        end else if (rd) begin
            m_pc = {rpc[31:2], 2'b00}; m_inst = 0; m_pc4 = 0; m_v = 0;
        end else begin
            m_inst = imem(m_pc); m_pc4 = m_pc + 4; m_v = 1; m_pc = m_pc + 4; m_cnt = m_cnt + 1;
        end
        e.pc = m_pc; e.inst = m_inst; e.pc4 = m_pc4; e.v = m_v; e.cnt = m_cnt;
        sb.push_back(e);
        @(posedge clk_i);
        #1;
        if (sb.size() == 0) begin
            chk("sb_empty", 32'd1, 32'd0);
        end else begin
            e = sb.pop_front();
            chk("pc", pc_o, e.pc);
            chk("inst", id_inst_o, e.inst);
            chk("op", {26'd0, id_op_o}, {26'd0, e.inst[31:26]});
            chk("pc4", id_pc_plus4_o, e.pc4);
            chk("valid", {31'd0, id_valid_o}, {31'd0, e.v});
            chk("cnt", fetch_cnt_o, e.cnt);
        end
    endtask

    initial begin
        // reset 2 cycles, idle 3 cycles (stall/redirect must be ignored while idle)
        cyc(1, 0, 0, 0, 0);
        cyc(1, 1, 1, 1, 32'h100);
        cyc(0, 0, 0, 0, 0);
        cyc(0, 0, 1, 0, 0);
        cyc(0, 0, 0, 1, 32'h200);
        chk("idle_pc", pc_o, 32'h0);
        // start: PC stays at reset value, first fetch on the next edge
        cyc(0, 1, 0, 0, 0);
        chk("start_pc", pc_o, 32'h0);
        cyc(0, 0, 0, 0, 0);
        chk("first_inst", id_inst_o, 32'h2008_0005);
        chk("first_op", {26'd0, id_op_o}, 32'h8);
        chk("first_pc4", id_pc_plus4_o, 32'h4);
        chk("first_cnt", fetch_cnt_o, 32'd1);
        // sequential fetch (start_i asserted in RUN is ignored)
        cyc(0, 1, 0, 0, 0);
        for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, 0);
        chk("seq_pc", pc_o, 32'd20);
        chk("seq_cnt", fetch_cnt_o, 32'd5);
        chk("lw_inst", id_inst_o, 32'h8C09_0000);
        // load-use stall for 2 cycles, then release
        cyc(0, 0, 1, 0, 0);
        cyc(0, 0, 1, 0, 0);
        chk("stall_pc", pc_o, 32'd20);
        chk("stall_cnt", fetch_cnt_o, 32'd5);
        cyc(0, 0, 0, 0, 0);
        chk("release_pc", pc_o, 32'd24);
        // redirect with misaligned target
        cyc(0, 0, 0, 1, 32'h0000_0043);
        chk("redir_pc", pc_o, 32'h40);
        chk("redir_valid", {31'd0, id_valid_o}, 32'd0);
        cyc(0, 0, 0, 0, 0);
        chk("redir_inst", id_inst_o, imem(32'h40));
        // stall and redirect together: nothing changes; redirect alone then taken
        cyc(0, 0, 1, 1, 32'h0000_0080);
        chk("stall_redir_pc", pc_o, 32'h44);
        cyc(0, 0, 0, 1, 32'h0000_0080);
        chk("redir2_pc", pc_o, 32'h80);
        cyc(0, 0, 0, 0, 0);
        // wrap at top of address space
        cyc(0, 0, 0, 1, 32'hFFFF_FFFF);
        chk("wrap_tgt", pc_o, 32'hFFFF_FFFC);
        cyc(0, 0, 0, 0, 0);
        chk("wrap_pc", pc_o, 32'h0);
        chk("wrap_pc4", id_pc_plus4_o, 32'h0);
        chk("wrap_valid", {31'd0, id_valid_o}, 32'd1);
        for (int i = 0; i < 4; i++) cyc(0, 0, (i == 2), 0, 0);
        // reset mid-run with stall asserted, then confirm IDLE via ignored activity
        cyc(1, 0, 1, 1, 32'h300);
        chk("rst_cnt", fetch_cnt_o, 32'd0);
        chk("rst_valid", {31'd0, id_valid_o}, 32'd0);
        cyc(0, 0, 0, 0, 0);
        cyc(0, 0, 0, 1, 32'h300);
        chk("idle_again_pc", pc_o, 32'h0);
        cyc(0, 1, 0, 0, 0);
        for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, 0);
        chk("restart_cnt", fetch_cnt_o, 32'd3);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
